shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock is the only clock, and reset is sampled only on the rising edge of clock.
REQ-002 Parameter EARLY_DONE, default 0, meaning: 1 ends the operation after the lowest set amount bit has been processed.
REQ-003 Port clock  input  1  system clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port ctrl_start  input  1  request; sampled only while the block is idle.
REQ-006 Port ctrl_shiftop  input  2  operation: 00 SLL, 01 SRA, 10 SRL (only when the macro is defined), 11 illegal.
REQ-007 Port ctrl_shiftamt  input  5  shift amount, 0-31.
REQ-008 Port data_operandA  input  32  operand; latched when the request is accepted.
REQ-009 Port data_result  output  32  registered result; held until the next accepted request.
REQ-010 Port data_resultRDY  output  1  one-cycle pulse that marks data_result as valid.
REQ-011 Port data_exception  output  1  one-cycle pulse, coincident with data_resultRDY, for an illegal op.
REQ-012 Port busy  output  1  high while an operation is in flight.

Function
REQ-013 The FSM SHALL have two states, IDLE and SHIFT, with a stage index k (3 bits) and registers holding the latched operand, amount and op.
REQ-014 In IDLE with ctrl_start=1 at edge t:
- latch the inputs;
- set k=4;
- enter SHIFT;
- set busy=1.
REQ-015 In SHIFT, each edge SHALL apply stage k to the working value, then decrement k:
- shift by 2^k when amt[k]=1;
- pass through unchanged when amt[k]=0.
REQ-016 Stage fill rules:
- SLL fills with zeros from the LSB end.
- SRA fills vacated MSBs with copies of the latched operand bit 31 (sign bit), for every stage.
- SRL fills vacated MSBs with zeros.
REQ-017 Final stage:
- With EARLY_DONE=0, the final stage is k=0.
- With EARLY_DONE=1, the final stage is the first k with amt[k-1:0]==0 (stage k=0 is always final).
REQ-018 On the edge that processes the final stage, the block SHALL:
- register the result into data_result;
- pulse data_resultRDY=1 for exactly one cycle;
- clear busy;
- return to IDLE.
REQ-019 Latency:
- With EARLY_DONE=0, the result SHALL be registered at edge t+5 for every amount.
- With EARLY_DONE=1, it SHALL be registered at edge t+5-j, where j = index of the lowest set amount bit.
- An amount of 0 with EARLY_DONE=1 SHALL register at edge t+1 with data_result=data_operandA.
REQ-020 ctrl_start while busy=1 SHALL be ignored; the in-flight operation and latched inputs SHALL be unaffected.
REQ-021 ctrl_start in the cycle where data_resultRDY=1 SHALL be accepted, because the block is already IDLE, giving back-to-back operation.
REQ-022 An illegal op (11, or 10 without the macro) SHALL skip SHIFT and, at edge t+1:
- set data_result=0;
- pulse data_resultRDY=1 and data_exception=1;
- keep busy low after that edge.
REQ-023 data_result SHALL change only on a final-stage edge or on reset; intermediate stage values SHALL NOT be visible on data_result.

Reset
REQ-024 On reset=1 at an edge, the block SHALL:
- enter IDLE;
- clear data_result, data_resultRDY, data_exception, busy, k and all latched registers to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation: no data_resultRDY pulse is produced for it, and ctrl_start is ignored in any cycle where reset=1.

Configuration
REQ-026 With macro SHIFT_SEQUENCER_SRL_EN defined, op 10 SHALL perform a logical right shift (zero fill).
REQ-027 Without SHIFT_SEQUENCER_SRL_EN, op 10 SHALL be treated as illegal per REQ-022, and no SRL fill logic SHALL be synthesized.

Verification
REQ-028 SRA, 0x80000000, amount 31, EARLY_DONE=0 -> data_result=0xFFFFFFFF and data_resultRDY high exactly 5 cycles after start, busy high throughout.
REQ-029 SLL, 0x00000001, amount 17: EARLY_DONE=0 -> result 0x00020000 at t+5; EARLY_DONE=1 -> the same result at t+5.
REQ-030 EARLY_DONE=1, SRA, 0xF0000000: amount 16 -> 0xFFFFF000 at t+1; amount 0 -> 0xF0000000 at t+1.
REQ-031 Start SLL 0x1 by 4, then pulse start with different operands at t+2 -> the second request is ignored and the result is 0x00000010; a new start in the data_resultRDY cycle is accepted.
REQ-032 Assert reset at t+3 of an operation -> no data_resultRDY pulse, all outputs 0 at the next edge, and the next start completes normally.
REQ-033 Op 10 with 0x80000000 by 4 -> with the macro: 0x08000000 at t+5; without the macro: data_exception and data_resultRDY pulse at t+1 with data_result=0.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one 2^k stage per clock, MSB stage first.
// Define SHIFT_SEQUENCER_SRL_EN to enable logical right shift (op 10).
module shift_sequencer #(
    parameter bit EARLY_DONE = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_start,
    input  logic [1:0]  ctrl_shiftop,
    input  logic [4:0]  ctrl_shiftamt,
    input  logic [31:0] data_operandA,
    output logic [31:0] data_result,
    output logic        data_resultRDY,
    output logic        data_exception,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRA = 2'b01,
        OP_SRL = 2'b10,
        OP_ILL = 2'b11
    } shift_op_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  amt_q, amt_d;
    shift_op_t   op_q, op_d;
    logic        sign_q, sign_d;
    logic [31:0] result_d;
    logic        rdy_d, exc_d, busy_d;

    logic [4:0]  step;
    logic [63:0] sra_ext;
    logic [31:0] stage_val;
    logic [4:0]  low_mask;
    logic        last_stage;

    function automatic logic op_legal(input shift_op_t op);
        logic legal;
        case (op)
            OP_SLL, OP_SRA: legal = 1'b1;
`ifdef SHIFT_SEQUENCER_SRL_EN
            OP_SRL:         legal = 1'b1;
`endif
            default:        legal = 1'b0;
        endcase
        return legal;
    endfunction

    // One stage of the shifter; SRA fills from the sign latched at accept.
    always_comb begin
        step      = 5'd1 << k_q;
        sra_ext   = {{32{sign_q}}, work_q} >> step;
        stage_val = work_q;
        if (amt_q[k_q]) begin
            case (op_q)
                OP_SLL:  stage_val = work_q << step;
                OP_SRA:  stage_val = sra_ext[31:0];
`ifdef SHIFT_SEQUENCER_SRL_EN
                OP_SRL:  stage_val = work_q >> step;
`endif
                default: stage_val = work_q;
            endcase
        end
    end

    // Early completion once every amount bit below the current stage is zero.
    always_comb begin
        low_mask   = ~(5'b11111 << k_q);
        last_stage = (k_q == 3'd0) || (EARLY_DONE && ((amt_q & low_mask) == 5'd0));
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        work_d   = work_q;
        amt_d    = amt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        result_d = data_result;
        rdy_d    = 1'b0;
        exc_d    = 1'b0;
        busy_d   = busy;
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    work_d  = data_operandA;
                    amt_d   = ctrl_shiftamt;
                    op_d    = shift_op_t'(ctrl_shiftop);
                    sign_d  = data_operandA[31];
                    k_d     = 3'd4;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (!op_legal(op_q)) begin
                    result_d = '0;
                    rdy_d    = 1'b1;
                    exc_d    = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    work_d = stage_val;
                    k_d    = k_q - 3'd1;
                    if (last_stage) begin
                        result_d = stage_val;
                        rdy_d    = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            k_q            <= '0;
            work_q         <= '0;
            amt_q          <= '0;
            op_q           <= OP_SLL;
            sign_q         <= 1'b0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            work_q         <= work_d;
            amt_q          <= amt_d;
            op_q           <= op_d;
            sign_q         <= sign_d;
            data_result    <= result_d;
            data_resultRDY <= rdy_d;
            data_exception <= exc_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: EARLY_DONE=0 and EARLY_DONE=1 instances share stimulus,
// each checked every cycle against a transaction-level model plus literal expectations.
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_start = 1'b0;
    logic [1:0]  ctrl_shiftop = 2'b00;
    logic [4:0]  ctrl_shiftamt = 5'd0;
    logic [31:0] data_operandA = 32'd0;

    logic [31:0] res [2];
    logic        rdy [2];
    logic        exc [2];
    logic        bsy [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    shift_sequencer #(.EARLY_DONE(1'b0)) dut0 (
        .clock(clock), .reset(reset), .ctrl_start(ctrl_start),
        .ctrl_shiftop(ctrl_shiftop), .ctrl_shiftamt(ctrl_shiftamt),
        .data_operandA(data_operandA), .data_result(res[0]),
        .data_resultRDY(rdy[0]), .data_exception(exc[0]), .busy(bsy[0])
    );

    shift_sequencer #(.EARLY_DONE(1'b1)) dut1 (
        .clock(clock), .reset(reset), .ctrl_start(ctrl_start),
        .ctrl_shiftop(ctrl_shiftop), .ctrl_shiftamt(ctrl_shiftamt),
        .data_operandA(data_operandA), .data_result(res[1]),
        .data_resultRDY(rdy[1]), .data_exception(exc[1]), .busy(bsy[1])
    );

    // Transaction model: result from plain shift operators, latency from the amount.
    function automatic logic ref_illegal(input logic [1:0] op);
`ifdef SHIFT_SEQUENCER_SRL_EN
        return op == 2'b11;
`else
        return op[1];
`endif
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [4:0] amt);
        logic signed [31:0] s;
        s = a;
        if (ref_illegal(op)) return 32'd0;
        case (op)
            2'b00:   return a << amt;
            2'b01:   return s >>> amt;
            default: return a >> amt;
        endcase
    endfunction

    function automatic int ref_lat(input logic early, input logic [4:0] amt, input logic illegal);
        if (illegal || !early) return illegal ? 1 : 5;
        if (amt == 5'd0) return 1;
        for (int j = 0; j < 5; j++)
            if (amt[j]) return 5 - j;
        return 5;
    endfunction

    logic [31:0] m_res [2];
    logic [31:0] m_pres [2];
    logic        m_rdy [2];
    logic        m_exc [2];
    logic        m_pexc [2];
    logic        m_busy [2];
    int          m_cnt [2];

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_res[d]  <= '0;
                m_pres[d] <= '0;
                m_rdy[d]  <= 1'b0;
                m_exc[d]  <= 1'b0;
                m_pexc[d] <= 1'b0;
                m_busy[d] <= 1'b0;
                m_cnt[d]  <= 0;
            end else begin
                m_rdy[d] <= 1'b0;
                m_exc[d] <= 1'b0;
                if (m_busy[d]) begin
                    if (m_cnt[d] == 1) begin
                        m_busy[d] <= 1'b0;
                        m_rdy[d]  <= 1'b1;
                        m_exc[d]  <= m_pexc[d];
                        m_res[d]  <= m_pres[d];
                    end else begin
                        m_cnt[d] <= m_cnt[d] - 1;
                    end
                end else if (ctrl_start) begin
                    m_busy[d] <= 1'b1;
                    m_pexc[d] <= ref_illegal(ctrl_shiftop);
                    m_pres[d] <= ref_result(ctrl_shiftop, data_operandA, ctrl_shiftamt);
                    m_cnt[d]  <= ref_lat(d == 1, ctrl_shiftamt, ref_illegal(ctrl_shiftop));
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Every cycle: advance to the falling edge and compare both DUTs with the model.
    task automatic tick();
        @(negedge clock);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("c%0d_res%0d", cyc, d), res[d], m_res[d]);
            check($sformatf("c%0d_rdy%0d", cyc, d), 32'(rdy[d]), 32'(m_rdy[d]));
            check($sformatf("c%0d_exc%0d", cyc, d), 32'(exc[d]), 32'(m_exc[d]));
            check($sformatf("c%0d_busy%0d", cyc, d), 32'(bsy[d]), 32'(m_busy[d]));
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
        ctrl_shiftop  = op;
        data_operandA = a;
        ctrl_shiftamt = amt;
        ctrl_start    = 1'b1;
        tick();
        ctrl_start    = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt,
                          output int n0, output int n1, output logic [31:0] r0,
                          output logic [31:0] r1, output logic e0, output logic e1);
        n0 = -1; n1 = -1; r0 = 'x; r1 = 'x; e0 = 1'bx; e1 = 1'bx;
        issue(op, a, amt);
        for (int i = 1; i <= 8 && (n0 < 0 || n1 < 0); i++) begin
            tick();
            if (rdy[0] && n0 < 0) begin n0 = i; r0 = res[0]; e0 = exc[0]; end
            if (rdy[1] && n1 < 0) begin n1 = i; r1 = res[1]; e1 = exc[1]; end
        end
    endtask

    task automatic expect_op(input string name, input logic [1:0] op, input logic [31:0] a,
                             input logic [4:0] amt, input int l0, input int l1,
                             input logic [31:0] rexp, input logic eexp);
        int n0, n1;
        logic [31:0] r0, r1;
        logic e0, e1;
        run_op(op, a, amt, n0, n1, r0, r1, e0, e1);
        check({name, "_lat0"}, 32'(n0), 32'(l0));
        check({name, "_lat1"}, 32'(n1), 32'(l1));
        check({name, "_res0"}, r0, rexp);
        check({name, "_res1"}, r1, rexp);
        check({name, "_exc0"}, 32'(e0), 32'(eexp));
        check({name, "_exc1"}, 32'(e1), 32'(eexp));
    endtask

    initial begin
        int n0, n1;
        logic [31:0] r0, r1;
        logic e0, e1;
        logic seen;

        reset = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_res%0d", d), res[d], 32'd0);
            check($sformatf("rst_rdy%0d", d), 32'(rdy[d]), 32'd0);
            check($sformatf("rst_busy%0d", d), 32'(bsy[d]), 32'd0);
        end
        reset = 1'b0;
        tick();

        expect_op("sra_min_31", 2'b01, 32'h8000_0000, 5'd31, 5, 5, 32'hFFFF_FFFF, 1'b0);
        expect_op("sll_1_17",   2'b00, 32'h0000_0001, 5'd17, 5, 5, 32'h0002_0000, 1'b0);
        expect_op("sra_f_16",   2'b01, 32'hF000_0000, 5'd16, 5, 1, 32'hFFFF_F000, 1'b0);
        expect_op("sra_f_0",    2'b01, 32'hF000_0000, 5'd0,  5, 1, 32'hF000_0000, 1'b0);
        expect_op("sra_pos_5",  2'b01, 32'h7FFF_FFFF, 5'd5,  5, 5, 32'h03FF_FFFF, 1'b0);
        expect_op("sll_dead_8", 2'b00, 32'hDEAD_BEEF, 5'd8,  5, 2, 32'hADBE_EF00, 1'b0);
        expect_op("sra_min_6",  2'b01, 32'h8000_0000, 5'd6,  5, 4, 32'hFE00_0000, 1'b0);
        expect_op("sll_3_31",   2'b00, 32'h0000_0003, 5'd31, 5, 5, 32'h8000_0000, 1'b0);
        expect_op("illegal_11", 2'b11, 32'h1234_5678, 5'd4,  1, 1, 32'h0000_0000, 1'b1);
`ifdef SHIFT_SEQUENCER_SRL_EN
        expect_op("srl_min_4",  2'b10, 32'h8000_0000, 5'd4,  5, 3, 32'h0800_0000, 1'b0);
`else
        expect_op("srl_off_4",  2'b10, 32'h8000_0000, 5'd4,  1, 1, 32'h0000_0000, 1'b1);
`endif

        // Start while busy is ignored; start in the ready cycle is accepted.
        n0 = -1; n1 = -1; r0 = 'x; r1 = 'x;
        issue(2'b00, 32'h0000_0001, 5'd4);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (rdy[0] && n0 < 0) begin n0 = i; r0 = res[0]; end
            if (rdy[1] && n1 < 0) begin n1 = i; r1 = res[1]; end
            if (i == 1) begin
                ctrl_shiftop  = 2'b01;
                data_operandA = 32'hFFFF_0000;
                ctrl_shiftamt = 5'd7;
                ctrl_start    = 1'b1;
            end
            if (i == 2) ctrl_start = 1'b0;
        end
        check("busy_ign_lat0", 32'(n0), 32'd5);
        check("busy_ign_lat1", 32'(n1), 32'd3);
        check("busy_ign_res0", r0, 32'h0000_0010);
        check("busy_ign_res1", r1, 32'h0000_0010);
        expect_op("b2b_sra_1", 2'b01, 32'h8000_0000, 5'd1, 5, 5, 32'hC000_0000, 1'b0);

        // Reset mid-operation aborts it; start during reset is ignored.
        seen = 1'b0;
        issue(2'b00, 32'h0000_00FF, 5'd3);
        tick();
        seen = seen | rdy[0] | rdy[1];
        tick();
        seen = seen | rdy[0] | rdy[1];
        reset         = 1'b1;
        ctrl_shiftop  = 2'b01;
        data_operandA = 32'hAAAA_5555;
        ctrl_shiftamt = 5'd2;
        ctrl_start    = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("abort_res%0d", d), res[d], 32'd0);
            check($sformatf("abort_rdy%0d", d), 32'(rdy[d]), 32'd0);
            check($sformatf("abort_exc%0d", d), 32'(exc[d]), 32'd0);
            check($sformatf("abort_busy%0d", d), 32'(bsy[d]), 32'd0);
        end
        reset      = 1'b0;
        ctrl_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | rdy[0] | rdy[1];
        end
        check("abort_no_rdy", 32'(seen), 32'd0);
        expect_op("post_abort", 2'b01, 32'h1234_5678, 5'd8, 5, 2, 32'h0012_3456, 1'b0);

        for (int i = 0; i < 8; i++)
            run_op(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)),
                   n0, n1, r0, r1, e0, e1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
